// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer types and widths, also consumed by rename and the LSQ.
package rob_pkg;

  localparam int unsigned PREG_WIDTH = 6;
  localparam int unsigned AREG_WIDTH = 5;
  localparam int unsigned PC_WIDTH   = 12;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  reg_write;
    logic [AREG_WIDTH-1:0] rd;
    logic [PREG_WIDTH-1:0] rd_tag;
    logic [PREG_WIDTH-1:0] old_tag;
    logic [PC_WIDTH-1:0]   pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / retirement / free-pool signal bundle for the reorder buffer.
interface reorder_buffer_if
  import rob_pkg::*;
#(
  parameter int unsigned IDX_W = 4
);

  logic                  alloc_valid;
  logic                  alloc_reg_write;
  logic [AREG_WIDTH-1:0] alloc_rd;
  logic [PREG_WIDTH-1:0] alloc_rd_tag;
  logic [PREG_WIDTH-1:0] alloc_old_tag;
  logic [PC_WIDTH-1:0]   alloc_pc;
  logic                  alloc_ready;
  logic [IDX_W-1:0]      alloc_idx;

  logic                  cmpl_valid;
  logic [IDX_W-1:0]      cmpl_idx;

  logic                  retire_valid;
  logic [AREG_WIDTH-1:0] retire_rd;
  logic [PREG_WIDTH-1:0] retire_rd_tag;
  logic [PC_WIDTH-1:0]   retire_pc;

  logic                  rob_push;
  logic [PREG_WIDTH-1:0] rob_free_reg;

  logic                  full;
  logic                  empty;
  logic [IDX_W:0]        count;

  modport master (
    output alloc_valid, alloc_reg_write, alloc_rd, alloc_rd_tag, alloc_old_tag, alloc_pc,
    output cmpl_valid, cmpl_idx,
    input  alloc_ready, alloc_idx,
    input  retire_valid, retire_rd, retire_rd_tag, retire_pc,
    input  rob_push, rob_free_reg,
    input  full, empty, count
  );

  modport slave (
    input  alloc_valid, alloc_reg_write, alloc_rd, alloc_rd_tag, alloc_old_tag, alloc_pc,
    input  cmpl_valid, cmpl_idx,
    output alloc_ready, alloc_idx,
    output retire_valid, retire_rd, retire_rd_tag, retire_pc,
    output rob_push, rob_free_reg,
    output full, empty, count
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue; returns the old physical tag of each retired
// register-writing instruction to the free pool.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  rob
);

  logic [IDX_W:0]   head;
  logic [IDX_W:0]   tail;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  rob_entry_t       entries [DEPTH];
  rob_entry_t       head_e;

  logic full_w;
  logic empty_w;
  logic do_alloc;
  logic do_cmpl;
  logic do_retire;
  logic do_push;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign head_e   = entries[head_idx];

  // Wrap bit distinguishes full from empty when the low index bits coincide.
  assign empty_w = (head == tail);
  assign full_w  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);

  assign rob.full        = full_w;
  assign rob.empty       = empty_w;
  assign rob.count       = tail - head;
  assign rob.alloc_ready = !full_w;
  assign rob.alloc_idx   = tail_idx;

  assign do_alloc  = rob.alloc_valid && !full_w;
  assign do_cmpl   = rob.cmpl_valid && entries[rob.cmpl_idx].valid;
  assign do_retire = !empty_w && head_e.valid && head_e.done;
  assign do_push   = do_retire && head_e.reg_write && (head_e.rd != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      head              <= '0;
      tail              <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      rob.retire_valid  <= 1'b0;
      rob.retire_rd     <= '0;
      rob.retire_rd_tag <= '0;
      rob.retire_pc     <= '0;
      rob.rob_push      <= 1'b0;
      rob.rob_free_reg  <= '0;
    end else begin
      rob.retire_valid <= do_retire;
      rob.rob_push     <= do_push;
      rob.rob_free_reg <= do_push ? head_e.old_tag : '0;
      if (do_retire) begin
        rob.retire_rd     <= head_e.rd;
        rob.retire_rd_tag <= head_e.rd_tag;
        rob.retire_pc     <= head_e.pc;
      end

      // Retire clears after completion so a late completion to the retiring head cannot resurrect it.
      if (do_cmpl) begin
        entries[rob.cmpl_idx].done <= 1'b1;
      end
      if (do_retire) begin
        entries[head_idx].valid <= 1'b0;
        entries[head_idx].done  <= 1'b0;
        head                    <= head + (IDX_W+1)'(1);
      end
      if (do_alloc) begin
        entries[tail_idx] <= '{valid:     1'b1,
                               done:      1'b0,
                               reg_write: rob.alloc_reg_write,
                               rd:        rob.alloc_rd,
                               rd_tag:    rob.alloc_rd_tag,
                               old_tag:   rob.alloc_old_tag,
                               pc:        rob.alloc_pc};
        tail              <= tail + (IDX_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements queued at accepted allocation.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  reorder_buffer_if #(.IDX_W(4)) bus ();

  reorder_buffer #(.DEPTH(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .rob (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [5:0]  rd_tag;
    logic [11:0] pc;
    logic        push;
    logic [5:0]  free;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (bus.retire_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", 32'(bus.retire_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check("retire_rd",     32'(bus.retire_rd),     32'(e.rd));
        check("retire_rd_tag", 32'(bus.retire_rd_tag), 32'(e.rd_tag));
        check("retire_pc",     32'(bus.retire_pc),     32'(e.pc));
        check("rob_push",      32'(bus.rob_push),      32'(e.push));
        check("rob_free_reg",  32'(bus.rob_free_reg),  32'(e.free));
      end
    end else if (bus.rob_push !== 1'b0) begin
      check("push_without_retire", 32'(bus.rob_push), 32'(0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic set_alloc(input logic rw, input logic [4:0] rd, input logic [5:0] tag,
                           input logic [5:0] old, input logic [11:0] pc);
    bus.alloc_valid     = 1'b1;
    bus.alloc_reg_write = rw;
    bus.alloc_rd        = rd;
    bus.alloc_rd_tag    = tag;
    bus.alloc_old_tag   = old;
    bus.alloc_pc        = pc;
  endtask

  task automatic do_alloc(input logic accept, input logic rw, input logic [4:0] rd,
                          input logic [5:0] tag, input logic [5:0] old, input logic [11:0] pc);
    exp_t e;
    set_alloc(rw, rd, tag, old, pc);
    if (accept) begin
      e.rd     = rd;
      e.rd_tag = tag;
      e.pc     = pc;
      e.push   = rw && (rd != 5'd0);
      e.free   = e.push ? old : 6'd0;
      sb.push_back(e);
    end
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [3:0] idx);
    bus.cmpl_valid = 1'b1;
    bus.cmpl_idx   = idx;
    step();
    bus.cmpl_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    int unsigned k = 0;
    while (bus.empty !== 1'b1 && k < 64) begin
      step();
      k++;
    end
    check(tag, 32'(bus.empty), 32'(1));
    check({tag, "_sb_left"}, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    bus.alloc_valid     = 1'b0;
    bus.alloc_reg_write = 1'b0;
    bus.alloc_rd        = '0;
    bus.alloc_rd_tag    = '0;
    bus.alloc_old_tag   = '0;
    bus.alloc_pc        = '0;
    bus.cmpl_valid      = 1'b0;
    bus.cmpl_idx        = '0;

    // Reset state
    do_reset();
    check("rst_empty",        32'(bus.empty),        32'(1));
    check("rst_full",         32'(bus.full),         32'(0));
    check("rst_count",        32'(bus.count),        32'(0));
    check("rst_alloc_ready",  32'(bus.alloc_ready),  32'(1));
    check("rst_rob_push",     32'(bus.rob_push),     32'(0));
    check("rst_retire_valid", 32'(bus.retire_valid), 32'(0));
    check("rst_alloc_idx",    32'(bus.alloc_idx),    32'(0));

    // Fill to capacity, then a dropped 17th alloc
    for (int i = 0; i < 16; i++) begin
      check("fill_alloc_idx", 32'(bus.alloc_idx), 32'(i));
      do_alloc(1'b1, 1'b1, 5'(i + 1), 6'(i + 16), 6'(i + 32), 12'(i * 4));
    end
    check("fill_full",        32'(bus.full),        32'(1));
    check("fill_count",       32'(bus.count),       32'(16));
    check("fill_alloc_ready", 32'(bus.alloc_ready), 32'(0));
    do_alloc(1'b0, 1'b1, 5'd20, 6'h3F, 6'h3E, 12'hFFF);
    check("drop_count", 32'(bus.count), 32'(16));

    complete(4'd0);
    check("cmpl_no_same_edge_retire", 32'(bus.retire_valid), 32'(0));
    step();
    check("first_retire_valid", 32'(bus.retire_valid), 32'(1));
    check("first_free_reg",     32'(bus.rob_free_reg), 32'(32));
    check("after_retire_count", 32'(bus.count),        32'(15));
    check("wrap_alloc_idx",     32'(bus.alloc_idx),    32'(0));
    do_alloc(1'b1, 1'b1, 5'd21, 6'd1, 6'd2, 12'h100);
    check("wrap_count", 32'(bus.count), 32'(16));

    // Alloc while full in the same cycle as a retirement is refused
    complete(4'd1);
    set_alloc(1'b1, 5'd22, 6'h3D, 6'h3C, 12'h200);
    step();
    bus.alloc_valid = 1'b0;
    check("sim_retire_valid", 32'(bus.retire_valid), 32'(1));
    check("sim_refused_count", 32'(bus.count), 32'(15));
    check("sim_alloc_idx", 32'(bus.alloc_idx), 32'(1));
    do_alloc(1'b1, 1'b1, 5'd23, 6'd3, 6'd4, 12'h300);
    check("sim_accept_count", 32'(bus.count), 32'(16));

    for (int k = 2; k < 18; k++) complete(4'(k % 16));
    drain("fill_drain");

    // Out-of-order completion, in-order retirement
    do_reset();
    do_alloc(1'b1, 1'b1, 5'd1, 6'd10, 6'd5, 12'h010);
    do_alloc(1'b1, 1'b1, 5'd2, 6'd11, 6'd6, 12'h014);
    do_alloc(1'b1, 1'b1, 5'd3, 6'd12, 6'd7, 12'h018);
    complete(4'd2);
    check("ooo_hold_a", 32'(bus.retire_valid), 32'(0));
    complete(4'd1);
    check("ooo_hold_b", 32'(bus.retire_valid), 32'(0));
    step();
    check("ooo_hold_c", 32'(bus.retire_valid), 32'(0));
    complete(4'd0);
    check("ooo_hold_d", 32'(bus.retire_valid), 32'(0));
    step();
    check("ooo_push_0", 32'(bus.rob_push),     32'(1));
    check("ooo_free_0", 32'(bus.rob_free_reg), 32'(5));
    step();
    check("ooo_push_1", 32'(bus.rob_push),     32'(1));
    check("ooo_free_1", 32'(bus.rob_free_reg), 32'(6));
    step();
    check("ooo_push_2", 32'(bus.rob_push),     32'(1));
    check("ooo_free_2", 32'(bus.rob_free_reg), 32'(7));
    step();
    check("ooo_idle",  32'(bus.retire_valid), 32'(0));
    check("ooo_empty", 32'(bus.empty),        32'(1));

    // Push suppression: non-writing instruction and rd = x0
    do_alloc(1'b1, 1'b0, 5'd3, 6'd20, 6'd9,  12'h020);
    do_alloc(1'b1, 1'b1, 5'd0, 6'd21, 6'd10, 12'h024);
    complete(4'd3);
    step();
    check("nowrite_retire", 32'(bus.retire_valid), 32'(1));
    check("nowrite_push",   32'(bus.rob_push),     32'(0));
    check("nowrite_free",   32'(bus.rob_free_reg), 32'(0));
    complete(4'd4);
    step();
    check("x0_retire", 32'(bus.retire_valid), 32'(1));
    check("x0_push",   32'(bus.rob_push),     32'(0));
    check("x0_free",   32'(bus.rob_free_reg), 32'(0));
    drain("suppress_drain");

    // Reset mid-operation discards in-flight entries
    for (int i = 0; i < 5; i++) do_alloc(1'b1, 1'b1, 5'(i + 4), 6'(i + 40), 6'(i + 50), 12'(i + 12'h400));
    complete(4'd7);
    complete(4'd8);
    complete(4'd9);
    check("mid_count", 32'(bus.count), 32'(5));
    rst = 1'b0;
    sb.delete();
    step();
    rst = 1'b1;
    check("mid_rst_empty",  32'(bus.empty),        32'(1));
    check("mid_rst_count",  32'(bus.count),        32'(0));
    check("mid_rst_push",   32'(bus.rob_push),     32'(0));
    check("mid_rst_retire", 32'(bus.retire_valid), 32'(0));
    complete(4'd2);
    step();
    step();
    check("stale_cmpl_retire", 32'(bus.retire_valid), 32'(0));
    check("stale_cmpl_push",   32'(bus.rob_push),     32'(0));
    check("stale_cmpl_empty",  32'(bus.empty),        32'(1));
    do_alloc(1'b1, 1'b1, 5'd9, 6'd33, 6'd34, 12'h500);
    complete(4'd0);
    drain("post_reset_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue. Entries are allocated at dispatch, marked complete by execute, and retired in program order.
- Producer end of the free-pool interface: on retirement it returns the previous physical mapping of the destination register through `rob_push` / `rob_free_reg`. This is the opposite end from rename, which pops the pool.
- Sits between the decode buffer/rename stage and the free pool. It runs alongside the LSQ.

Parameters:
- DEPTH, 16, number of entries (power of two)
- IDX_W, 4, log2(DEPTH)
- PREG_WIDTH, 6, physical register tag width
- AREG_WIDTH, 5, architectural register index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- alloc_valid  in  1  dispatch requests an entry this cycle
- alloc_reg_write  in  1  instruction writes rd
- alloc_rd  in  AREG_WIDTH  architectural destination
- alloc_rd_tag  in  PREG_WIDTH  new physical tag for rd
- alloc_old_tag  in  PREG_WIDTH  previous physical tag of rd
- alloc_pc  in  12  instruction PC
- alloc_ready  out  1  equals !full
- alloc_idx  out  IDX_W  index that an accepted alloc receives (the tail)
- cmpl_valid  in  1  execute reports completion
- cmpl_idx  in  IDX_W  ROB index that completed
- retire_valid  out  1  one entry retired last edge
- retire_rd  out  AREG_WIDTH  retired rd
- retire_rd_tag  out  PREG_WIDTH  retired new tag (ARF commit)
- retire_pc  out  12  retired PC
- rob_push  out  1  push `rob_free_reg` into the free pool
- rob_free_reg  out  PREG_WIDTH  freed physical tag (old tag)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  IDX_W+1  occupied entries

Behaviour:
- **Storage.** Per entry: valid, done, reg_write, rd, rd_tag, old_tag, pc.
- **Pointers.** head and tail are IDX_W+1 bits; the MSB is a wrap bit.
  - empty = (head == tail).
  - full = low bits equal and MSBs differ.
  - count = tail - head, modulo 2^(IDX_W+1).
- **Reset** (rst==0 at an edge):
  - head, tail, all valid and done bits cleared.
  - All registered outputs go to 0: retire_valid, rob_push, rob_free_reg, retire_rd, retire_rd_tag, retire_pc.
  - empty=1, full=0, alloc_ready=1.
  - Reset mid-operation discards every in-flight entry. No push occurs for discarded entries.
- **Allocate.** Accepted when alloc_valid && !full, with full sampled at the start of the cycle.
  - Writes the entry at tail[IDX_W-1:0] with valid=1, done=0; tail increments.
  - alloc_valid while full is dropped, with no state change. Dispatch must stall on alloc_ready.
- **Complete.** When cmpl_valid and entry[cmpl_idx].valid, set done=1.
  - Completion to an invalid entry is ignored.
  - Completion to an already-done entry has no effect.
- **Retire.** At most one entry per cycle. Condition: !empty && entry[head].valid && entry[head].done, evaluated on pre-edge state.
  - At the edge: clear valid/done, head increments, registered retire outputs load.
  - retire_valid=1 for exactly one cycle per retired entry.
  - rob_push = retire && reg_write && (rd != 0). Pushes for x0 or for non-writing instructions are suppressed.
  - rob_free_reg = old_tag when rob_push, else 0.
- **Latency.**
  - A completion at edge N makes the head eligible in cycle N+1; it retires at edge N+1.
  - rob_push is visible during the cycle after edge N+1.
  - Back-to-back done entries retire on consecutive cycles.
- **Simultaneous events.**
  - Alloc and retire in the same cycle: both occur; count is unchanged. When full, alloc is still refused that cycle.
  - Complete and retire to the same head index in the same cycle: the retire check uses the old done=0, so retirement happens the next cycle.
  - Alloc and complete to the same index: the completion is ignored because the entry is invalid at the start of the cycle.
- **Wrap-around.** Low index bits wrap from DEPTH-1 to 0 and the MSB toggles. alloc_idx and cmpl_idx use the low bits only.
- **Combinational outputs.** full, empty, count, alloc_ready and alloc_idx derive only from registered pointers.

Decomposition:
- Shared package `rob_pkg` holds:
  - `rob_entry_t` packed struct (valid, done, reg_write, rd, rd_tag, old_tag, pc)
  - PREG_WIDTH, AREG_WIDTH and PC width constants (shared with rename and the LSQ)
- No sub-module. Pointer/flag logic and the entry array are a single module.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, then release -> empty=1, full=0, count=0, alloc_ready=1, rob_push=0, retire_valid=0.
2. Fill: 16 allocs -> full=1, count=16, alloc_ready=0. A 17th alloc (rd_tag=6'h3F) is dropped; after one retirement, the next alloc lands at idx 0 (wrap).
3. Out-of-order completion: alloc idx 0/1/2 with old_tag 5/6/7, all reg_write=1, rd!=0. Complete in order 2, 1, 0 -> no retire until 0 completes; then rob_free_reg = 5, 6, 7 on three consecutive cycles, each with rob_push=1.
4. Push suppression: retire an entry with reg_write=0 and one with rd=0 -> retire_valid=1, rob_push=0, rob_free_reg=0 for both.
5. Simultaneous: at count=16, assert alloc and retire the head in the same cycle -> alloc refused, count=15. Next cycle alloc accepted -> count=16.
6. Reset mid-operation: 5 entries valid, 3 done -> rst=0 for one edge. No rob_push follows; empty=1; a later cmpl_idx=2 is ignored.
